// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES state typedefs, byte addressing and row rotation
//               helpers for the forward and inverse ShiftRows engines.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int STATE_W = 128;
    localparam int BYTE_W  = 8;

    typedef logic [0:STATE_W-1] aes_state_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } srs_state_t;

    // Column-major byte addressing; bit 0 of the state is the MSB of byte (0,0).
    function automatic int byte_idx(input int r, input int c);
        return c * 4 * BYTE_W + r * BYTE_W;
    endfunction

    function automatic aes_state_t rotl_row(input aes_state_t s, input int r);
        aes_state_t o;
        o = s;
        for (int c = 0; c < 4; c++) begin
            o[byte_idx(r, c) +: BYTE_W] = s[byte_idx(r, (c + 1) % 4) +: BYTE_W];
        end
        return o;
    endfunction

    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t o;
        o = s;
        for (int r = 1; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[byte_idx(r, c) +: BYTE_W] = s[byte_idx(r, (c + r) % 4) +: BYTE_W];
            end
        end
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_rows_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_rows_seq_if
// Description : Load/unload handshake bundle for the ShiftRows engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_rows_seq_if;
    import aes_pkg::*;

    logic       flush;
    logic       in_valid;
    logic       in_ready;
    aes_state_t Data;
    logic       out_valid;
    logic       out_ready;
    aes_state_t Result;
    logic       busy;

    modport master (
        output flush, in_valid, Data, out_ready,
        input  in_ready, out_valid, Result, busy
    );

    modport slave (
        input  flush, in_valid, Data, out_ready,
        output in_ready, out_valid, Result, busy
    );

endinterface
`default_nettype wire

// File: rtl/shift_rows_seq.sv
`default_nettype none
// ============================================================================
// Module      : shift_rows_seq
// Description : Forward AES ShiftRows, one byte rotation per cycle on all
//               pending rows (FAST=1 shifts fully in the load cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module shift_rows_seq
    import aes_pkg::*;
#(
    parameter int FAST    = 0,
    parameter int STATE_W = 128
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    shift_rows_seq_if.slave bus
);

    generate
        if (STATE_W != aes_pkg::STATE_W) begin : g_bad_width
            $error("shift_rows_seq: only a 128-bit state is supported");
        end
    endgenerate

    srs_state_t r_state;
    srs_state_t w_next;
    logic [1:0] r_step;
    aes_state_t r_data;
    aes_state_t w_rot;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (bus.flush) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (bus.in_valid) w_next = (FAST != 0) ? DONE : ROTATE;
                ROTATE:  if (r_step == 2'd2) w_next = DONE;
                DONE:    if (bus.out_ready) w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    // Row r stops moving once it has been rotated r times, i.e. when step reaches r.
    always_comb begin
        w_rot = r_data;
        for (int r = 1; r < 4; r++) begin
            if (r > int'(r_step)) begin
                w_rot = rotl_row(w_rot, r);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data <= '0;
            r_step <= 2'd0;
        end else if (bus.flush) begin
            r_data <= '0;
            r_step <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_data <= (FAST != 0) ? shift_rows(bus.Data) : bus.Data;
                        r_step <= 2'd0;
                    end
                end
                ROTATE: begin
                    r_data <= w_rot;
                    r_step <= r_step + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (r_state)
            IDLE:    bus.in_ready = 1'b1;
            ROTATE:  bus.busy = 1'b1;
            DONE: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
            end
            default: begin
            end
        endcase
        bus.Result = r_data;
    end

endmodule
`default_nettype wire
